// File: rtl/xc20xx_clbse_pkg.sv
// Shared codes and field layout for the XC20XX CLB storage-element control mux.
package xc20xx_clbse_pkg;

  localparam int unsigned CFG_BITS = 6;

  // Field bit offsets within the active configuration word.
  localparam int unsigned CLKIN_LSB  = 0;
  localparam int unsigned CLKPOL_LSB = 2;
  localparam int unsigned RMUX_LSB   = 4;

  localparam logic [1:0] CLKIN_GND = 2'b00;
  localparam logic [1:0] CLKIN_K   = 2'b01;
  localparam logic [1:0] CLKIN_C   = 2'b10;
  localparam logic [1:0] CLKIN_G   = 2'b11;

  localparam logic [1:0] POL_GND  = 2'b00;
  localparam logic [1:0] POL_TRUE = 2'b01;
  localparam logic [1:0] POL_INV  = 2'b10;

  localparam logic [1:0] R_GND = 2'b00;
  localparam logic [1:0] R_D   = 2'b01;
  localparam logic [1:0] R_G   = 2'b10;

endpackage

// File: rtl/xc20xx_cfg_chain.sv
// Serial configuration chain: shadow shift register, committed active word and valid flag.
// Readback on dout_o is present only when XC20XX_CLBSE_CFG_READBACK_EN is defined.
module xc20xx_cfg_chain
  import xc20xx_clbse_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                din_i,
  input  logic                shift_i,
  input  logic                load_i,
  output logic [CFG_BITS-1:0] active_o,
  output logic                valid_o,
  output logic                dout_o
);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic                valid_q, valid_d;

  // Commit takes the pre-shift shadow, so shift and load on one edge compose cleanly.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    valid_d  = valid_q;
    if (shift_i) shadow_d = {din_i, shadow_q[CFG_BITS-1:1]};
    if (load_i) begin
      active_d = shadow_q;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      valid_q  <= valid_d;
    end
  end

  assign active_o = active_q;
  assign valid_o  = valid_q;

`ifdef XC20XX_CLBSE_CFG_READBACK_EN
  assign dout_o = shadow_q[0];
`else
  assign dout_o = 1'b0;
`endif

endmodule

// File: rtl/xc20xx_clbse_ctrl_mux.sv
// CLB storage-element control mux: clock source, clock polarity and reset source selection.
// Optional CFG_DOUT readback via XC20XX_CLBSE_CFG_READBACK_EN.
module xc20xx_clbse_ctrl_mux
  import xc20xx_clbse_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic CFG_DIN,
  input  logic CFG_SHIFT,
  input  logic CFG_LOAD,
  output logic CFG_DOUT,
  output logic CFG_VALID,
  input  logic K,
  input  logic C,
  input  logic D,
  input  logic G,
  output logic CLK_SIG,
  output logic CLK_IN,
  output logic R_IN
);

  logic [CFG_BITS-1:0] active;
  logic [1:0]          clkin_sel, clkpol_sel, rmux_sel;

  xc20xx_cfg_chain u_cfg_chain (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .din_i    (CFG_DIN),
    .shift_i  (CFG_SHIFT),
    .load_i   (CFG_LOAD),
    .active_o (active),
    .valid_o  (CFG_VALID),
    .dout_o   (CFG_DOUT)
  );

  assign clkin_sel  = active[CLKIN_LSB +: 2];
  assign clkpol_sel = active[CLKPOL_LSB +: 2];
  assign rmux_sel   = active[RMUX_LSB +: 2];

  always_comb begin
    CLK_SIG = 1'b0;
    case (clkin_sel)
      CLKIN_K: CLK_SIG = K;
      CLKIN_C: CLK_SIG = C;
      CLKIN_G: CLK_SIG = G;
      default: CLK_SIG = 1'b0;
    endcase
  end

  // Inverting a grounded source legitimately yields a constant-high clock.
  always_comb begin
    CLK_IN = 1'b0;
    case (clkpol_sel)
      POL_TRUE: CLK_IN = CLK_SIG;
      POL_INV:  CLK_IN = ~CLK_SIG;
      default:  CLK_IN = 1'b0;
    endcase
  end

  always_comb begin
    R_IN = 1'b0;
    case (rmux_sel)
      R_D:     R_IN = D;
      R_G:     R_IN = G;
      default: R_IN = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_xc20xx_clbse_ctrl_mux.sv
// Scoreboard bench for xc20xx_clbse_ctrl_mux; expectations come from a spec-level model.
module tb_xc20xx_clbse_ctrl_mux;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_din, cfg_shift, cfg_load;
  logic cfg_dout, cfg_valid;
  logic k, c, d, g;
  logic clk_sig, clk_in, r_in;

  always #5 clk = ~clk;

  xc20xx_clbse_ctrl_mux dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .CFG_DIN   (cfg_din),
    .CFG_SHIFT (cfg_shift),
    .CFG_LOAD  (cfg_load),
    .CFG_DOUT  (cfg_dout),
    .CFG_VALID (cfg_valid),
    .K         (k),
    .C         (c),
    .D         (d),
    .G         (g),
    .CLK_SIG   (clk_sig),
    .CLK_IN    (clk_in),
    .R_IN      (r_in)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] m_sh, m_act;
  logic       m_valid;
  logic [4:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got={valid,sig,clkin,rin,dout}=%b expected=%b", tag, got, exp);
  endtask

  function automatic logic [4:0] model_out();
    logic sig, cin, rin, dout;
    case (m_act[1:0])
      2'b01:   sig = k;
      2'b10:   sig = c;
      2'b11:   sig = g;
      default: sig = 1'b0;
    endcase
    case (m_act[3:2])
      2'b01:   cin = sig;
      2'b10:   cin = ~sig;
      default: cin = 1'b0;
    endcase
    case (m_act[5:4])
      2'b01:   rin = d;
      2'b10:   rin = g;
      default: rin = 1'b0;
    endcase
`ifdef XC20XX_CLBSE_CFG_READBACK_EN
    dout = m_sh[0];
`else
    dout = 1'b0;
`endif
    return {m_valid, sig, cin, rin, dout};
  endfunction

  task automatic sample(input string tag);
    logic [4:0] exp;
    exp_q.push_back(model_out());
    #1;
    exp = exp_q.pop_front();
    check_eq(tag, {cfg_valid, clk_sig, clk_in, r_in, cfg_dout}, exp);
  endtask

  task automatic model_reset();
    m_sh = '0; m_act = '0; m_valid = 1'b0;
  endtask

  task automatic cfg_step(input logic shift, input logic load, input logic din, input string tag);
    @(negedge clk);
    cfg_shift = shift; cfg_load = load; cfg_din = din;
    @(posedge clk);
    if (load) begin m_act = m_sh; m_valid = 1'b1; end
    if (shift) m_sh = {din, m_sh[5:1]};
    #1;
    cfg_shift = 1'b0; cfg_load = 1'b0;
    sample(tag);
  endtask

  task automatic shift_word(input logic [5:0] w, input string tag);
    for (int i = 0; i < 6; i++) cfg_step(1'b1, 1'b0, w[i], tag);
  endtask

  task automatic sweep_pins(input string tag);
    for (int v = 0; v < 16; v++) begin
      {k, c, d, g} = v[3:0];
      sample(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_din = 1'b0; cfg_shift = 1'b0; cfg_load = 1'b0;
    {k, c, d, g} = 4'b1111;
    model_reset();
    #2;
    sample("reset_async");

    @(negedge clk);
    rst_n = 1'b1;
    sample("reset_release");

    shift_word(6'b01_01_01, "shift_kd");
    cfg_step(1'b0, 1'b1, 1'b0, "load_kd");
    sweep_pins("sel_kd");

    shift_word(6'b10_10_11, "shift_ginv");
    cfg_step(1'b0, 1'b1, 1'b0, "load_ginv");
    sweep_pins("sel_ginv");

    shift_word(6'b01_01_01, "shift_kd2");
    cfg_step(1'b0, 1'b1, 1'b0, "load_kd2");
    for (int i = 0; i < 6; i++) begin
      {k, c, d, g} = 4'(i * 5 + 3);
      cfg_step(1'b1, 1'b0, i[0], "shift_no_commit");
    end

    shift_word(6'b10_01_10, "shift_sim");
    {k, c, d, g} = 4'b0110;
    cfg_step(1'b1, 1'b1, 1'b1, "shift_and_load");
    cfg_step(1'b0, 1'b1, 1'b0, "load_shifted_shadow");
    sweep_pins("sel_shadow_110011");

    shift_word(6'b01_11_01, "shift_pol_rsvd");
    cfg_step(1'b0, 1'b1, 1'b0, "load_pol_rsvd");
    sweep_pins("pol_reserved");

    shift_word(6'b00_10_00, "shift_gnd_inv");
    cfg_step(1'b0, 1'b1, 1'b0, "load_gnd_inv");
    sweep_pins("gnd_inverted");

    // Fresh block for readback: word then six flushing shifts.
    @(negedge clk);
    rst_n = 1'b0; model_reset();
    #1 rst_n = 1'b1;
    shift_word(6'b101100, "rb_fill");
    for (int i = 0; i < 6; i++) cfg_step(1'b1, 1'b0, 1'b0, "rb_flush");

    // Asynchronous reset mid-shift discards the partial word.
    shift_word(6'b11_01_01, "pre_abort");
    cfg_step(1'b0, 1'b1, 1'b0, "pre_abort_load");
    cfg_step(1'b1, 1'b0, 1'b1, "partial");
    cfg_step(1'b1, 1'b0, 1'b1, "partial");
    {k, c, d, g} = 4'b1111;
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    sample("reset_mid_shift");
    @(negedge clk);
    rst_n = 1'b1;
    cfg_step(1'b0, 1'b1, 1'b0, "load_after_abort");
    sweep_pins("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/xc20xx_clbse_ctrl_mux.md
# xc20xx_clbse_ctrl_mux

Configurable control-path multiplexer for the XC20XX CLB storage element. It selects the storage clock source (K, C or G), applies the configured clock polarity, and selects the asynchronous reset source (D or G) for the CLB flip-flop or latch. Selection bits arrive through a serial configuration chain clocked by the single configuration clock and take effect only on an explicit commit. The block sits between the CLB input pins/LUT outputs and the storage primitive.

## Interface
Parameters:
- CFG_BITS, 6, width of the configuration word; fixed, not user-overridable.

Ports:
- CLK  in  1  configuration clock; all state updates on its rising edge.
- RST_N  in  1  asynchronous, active-low reset; clears the shadow and active configuration.
- CFG_DIN  in  1  serial configuration data.
- CFG_SHIFT  in  1  shifts CFG_DIN into the shadow register this edge.
- CFG_LOAD  in  1  commits the shadow register to the active configuration this edge.
- CFG_DOUT  out  1  serial chain output (see Configuration).
- CFG_VALID  out  1  high once at least one commit has occurred since reset.
- K  in  1  CLB clock pin.
- C  in  1  CLB input C.
- D  in  1  CLB input D.
- G  in  1  G LUT output.
- CLK_SIG  out  1  selected clock source, before polarity.
- CLK_IN  out  1  polarity-adjusted storage clock.
- R_IN  out  1  storage reset/clear request.

## Operation
Active word fields:
- [1:0] CLKIN_SEL:
  - 00 gives constant 0.
  - 01 gives K.
  - 10 gives C.
  - 11 gives G.
- [3:2] CLKPOL_SEL:
  - 00 gives constant 0.
  - 01 gives CLK_SIG.
  - 10 gives ~CLK_SIG.
  - 11 is reserved and gives constant 0.
- [5:4] RMUX_SEL:
  - 00 gives constant 0.
  - 01 gives D.
  - 10 gives G.
  - 11 is reserved and gives constant 0.

Configuration chain:
- Shift: when CFG_SHIFT=1, shadow <= {CFG_DIN, shadow[5:1]}. After 6 shifts, the first bit sent is in bit 0.
- Commit: when CFG_LOAD=1, active <= shadow as it stood before this edge. CFG_VALID is set to 1 on that edge.
- Shift and load in the same edge: both happen. Active gets the pre-shift shadow; shadow shifts.
- Neither asserted: registers hold.

Datapath:
- CLK_SIG, CLK_IN and R_IN are purely combinational from K/C/D/G and the active register.
- Shifting alone never changes them.
- CLKIN_SEL=00 with CLKPOL_SEL=10 drives CLK_IN=1. This is legal and must not be masked.

## Timing
- Reset (RST_N low, asynchronous):
  - shadow=0, active=0, CFG_VALID=0.
  - CLK_SIG=0, CLK_IN=0, R_IN=0 immediately, regardless of CLK.
  - CFG_DOUT=0.
- Release of RST_N is sampled synchronously; the first shift may occur on the first rising CLK edge with RST_N high.
- Commit latency: outputs reflect the new selection combinationally after the CLK edge on which CFG_LOAD=1.
- Data path latency: zero cycles, combinational from K/C/D/G to outputs.
- Reset asserted mid-shift or mid-commit: the partial word is discarded and all state returns to reset values.

## Configuration
- Macro: XC20XX_CLBSE_CFG_READBACK_EN.
- Defined: CFG_DOUT = shadow[0], registered. A chain of blocks can then be daisy-chained, and an unshifted word reads back after 6 shifts.
- Undefined: CFG_DOUT is tied to 0 and readback logic is omitted. All other behaviour is identical.

## Structure
- Shared package xc20xx_clbse_pkg holds:
  - CLKIN_SEL codes: CLKIN_GND, CLKIN_K, CLKIN_C, CLKIN_G.
  - CLKPOL codes: POL_GND, POL_TRUE, POL_INV.
  - RMUX codes: R_GND, R_D, R_G.
  - Field bit offsets and CFG_BITS.
- One sub-module: xc20xx_cfg_chain, which holds the shadow/active registers, the CFG_VALID flag and readback.
- The three selection muxes stay in the top module as combinational case statements. Reserved codes use a default arm that drives 0.

## Test plan
- Reset: RST_N=0 with K=C=D=G=1 -> CLK_IN=0, R_IN=0, CLK_SIG=0, CFG_VALID=0, asynchronously and without a CLK edge.
- Load word 6'b01_01_01: shift bits 1,0,1,0,1,0, then pulse CFG_LOAD -> CLK_IN follows K, R_IN follows D, CFG_VALID=1. Toggling C/G has no effect.
- Inverted G clock: load 6'b10_10_11 -> CLK_IN = ~G and R_IN = G. G=1 gives CLK_IN=0, R_IN=1.
- Shift without commit: active=6'b01_01_01, then shift 6 new bits without CFG_LOAD -> outputs unchanged throughout.
- Simultaneous shift and load with shadow=6'b10_01_10 and CFG_DIN=1 -> active=6'b10_01_10 and shadow=6'b110_011. Also load reserved code 11 in CLKPOL_SEL -> CLK_IN=0.
- Readback (macro defined): shift 6'b101100 into a reset block, then 6 more shifts -> CFG_DOUT sequence 0,0,1,1,0,1. With the macro undefined -> CFG_DOUT stays 0.
